// File: rtl/led_phase_scheduler.sv
// rtl/led_phase_scheduler.sv - RED/AMBIENT/IR LED phase sequencer with per-phase ADC averaging
module led_phase_scheduler #(
  parameter int SETTLE_CYC  = 3,
  parameter int SAMPLE_LOG2 = 2
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       Enable,
  input  logic [7:0] ADC,
  input  logic [3:0] LED_DRIVE_Set,
  input  logic [6:0] RED_DC_Comp,
  input  logic [3:0] RED_PGA,
  input  logic [6:0] IR_DC_Comp,
  input  logic [3:0] IR_PGA,
  output logic       LED_RED,
  output logic       LED_IR,
  output logic [3:0] LED_DRIVE,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic [7:0] RED_ADC_Value,
  output logic [7:0] IR_ADC_Value,
  output logic [7:0] AMB_ADC_Value,
  output logic [7:0] RED_Corr,
  output logic [7:0] IR_Corr,
  output logic       Frame_Valid,
  output logic       Busy
);

  localparam int N  = 1 << SAMPLE_LOG2;
  localparam int AW = 8 + SAMPLE_LOG2;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [4:0] SAMPLE_LAST = 5'(N - 1);

  localparam logic [1:0] PH_RED = 2'd0;
  localparam logic [1:0] PH_AMB = 2'd1;
  localparam logic [1:0] PH_IR  = 2'd2;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t          state;
  logic [1:0]      phase;
  logic [3:0]      settle_cnt;
  logic [4:0]      sample_cnt;
  logic [AW-1:0]   acc;
  logic [3:0]      sh_drive;
  logic [6:0]      sh_red_dc;
  logic [3:0]      sh_red_pga;
  logic [6:0]      sh_ir_dc;
  logic [3:0]      sh_ir_pga;
  logic [7:0]      red_avg;
  logic [7:0]      amb_avg;

  logic [AW-1:0]   acc_sum;
  logic [AW-1:0]   acc_shift;
  logic [7:0]      avg;
  logic [7:0]      red_corr_n;
  logic [7:0]      ir_corr_n;
  logic            sample_last;
  logic            frame_start;

  assign acc_sum     = acc + AW'(ADC);
  assign acc_shift   = acc_sum >> SAMPLE_LOG2;
  assign avg         = acc_shift[7:0];
  assign red_corr_n  = (red_avg > amb_avg) ? (red_avg - amb_avg) : 8'd0;
  assign ir_corr_n   = (avg > amb_avg) ? (avg - amb_avg) : 8'd0;
  assign sample_last = (sample_cnt == SAMPLE_LAST);

  // Frame start covers both the first frame out of IDLE and the gapless restart after IR completes.
  assign frame_start = Enable &&
                       ((state == IDLE) ||
                        (state == SAMPLE && phase == PH_IR && sample_last));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      phase         <= PH_RED;
      settle_cnt    <= 4'd0;
      sample_cnt    <= 5'd0;
      acc           <= '0;
      sh_drive      <= 4'd0;
      sh_red_dc     <= 7'd0;
      sh_red_pga    <= 4'd0;
      sh_ir_dc      <= 7'd0;
      sh_ir_pga     <= 4'd0;
      red_avg       <= 8'd0;
      amb_avg       <= 8'd0;
      LED_RED       <= 1'b0;
      LED_IR        <= 1'b0;
      LED_DRIVE     <= 4'd0;
      DC_Comp       <= 7'd0;
      PGA_Gain      <= 4'd0;
      RED_ADC_Value <= 8'd0;
      IR_ADC_Value  <= 8'd0;
      AMB_ADC_Value <= 8'd0;
      RED_Corr      <= 8'd0;
      IR_Corr       <= 8'd0;
      Frame_Valid   <= 1'b0;
      Busy          <= 1'b0;
    end else begin
      Frame_Valid <= 1'b0;
      if (!Enable) begin
        // Abort: drop the frame in progress, keep the last published values.
        if (state != IDLE) begin
          state      <= IDLE;
          phase      <= PH_RED;
          settle_cnt <= 4'd0;
          sample_cnt <= 5'd0;
          acc        <= '0;
          LED_RED    <= 1'b0;
          LED_IR     <= 1'b0;
          LED_DRIVE  <= 4'd0;
          DC_Comp    <= 7'd0;
          PGA_Gain   <= 4'd0;
          Busy       <= 1'b0;
        end
      end else if (frame_start) begin
        if (state == SAMPLE) begin
          RED_ADC_Value <= red_avg;
          AMB_ADC_Value <= amb_avg;
          IR_ADC_Value  <= avg;
          RED_Corr      <= red_corr_n;
          IR_Corr       <= ir_corr_n;
          Frame_Valid   <= 1'b1;
        end
        sh_drive   <= LED_DRIVE_Set;
        sh_red_dc  <= RED_DC_Comp;
        sh_red_pga <= RED_PGA;
        sh_ir_dc   <= IR_DC_Comp;
        sh_ir_pga  <= IR_PGA;
        state      <= SETTLE;
        phase      <= PH_RED;
        settle_cnt <= 4'd0;
        sample_cnt <= 5'd0;
        acc        <= '0;
        Busy       <= 1'b1;
        LED_RED    <= 1'b1;
        LED_IR     <= 1'b0;
        LED_DRIVE  <= LED_DRIVE_Set;
        DC_Comp    <= RED_DC_Comp;
        PGA_Gain   <= RED_PGA;
      end else begin
        case (state)
          SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state      <= SAMPLE;
              sample_cnt <= 5'd0;
              acc        <= '0;
            end else begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end
          SAMPLE: begin
            if (sample_last) begin
              state      <= SETTLE;
              settle_cnt <= 4'd0;
              if (phase == PH_RED) begin
                red_avg <= avg;
                phase   <= PH_AMB;
                LED_RED <= 1'b0;
              end else begin
                amb_avg  <= avg;
                phase    <= PH_IR;
                LED_IR   <= 1'b1;
                DC_Comp  <= sh_ir_dc;
                PGA_Gain <= sh_ir_pga;
              end
            end else begin
              acc        <= acc_sum;
              sample_cnt <= sample_cnt + 5'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_phase_scheduler.sv
// tb/tb_led_phase_scheduler.sv - directed table-driven bench for led_phase_scheduler
module tb_led_phase_scheduler;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       Enable;
  logic [7:0] ADC;
  logic [3:0] LED_DRIVE_Set;
  logic [6:0] RED_DC_Comp;
  logic [3:0] RED_PGA;
  logic [6:0] IR_DC_Comp;
  logic [3:0] IR_PGA;
  logic       LED_RED, LED_IR;
  logic [3:0] LED_DRIVE;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;
  logic [7:0] RED_ADC_Value, IR_ADC_Value, AMB_ADC_Value, RED_Corr, IR_Corr;
  logic       Frame_Valid, Busy;

  led_phase_scheduler dut (
    .CLK(CLK), .rst_n(rst_n), .Enable(Enable), .ADC(ADC),
    .LED_DRIVE_Set(LED_DRIVE_Set), .RED_DC_Comp(RED_DC_Comp), .RED_PGA(RED_PGA),
    .IR_DC_Comp(IR_DC_Comp), .IR_PGA(IR_PGA),
    .LED_RED(LED_RED), .LED_IR(LED_IR), .LED_DRIVE(LED_DRIVE),
    .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
    .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value),
    .AMB_ADC_Value(AMB_ADC_Value), .RED_Corr(RED_Corr), .IR_Corr(IR_Corr),
    .Frame_Valid(Frame_Valid), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] settle;
    logic [7:0] r0, r1, r2, r3;
    logic [7:0] amb, ir;
    logic [7:0] e_red, e_amb, e_ir, e_rc, e_ic;
  } vec_t;

  vec_t vecs[5];
  int total = 0;
  int bad   = 0;

  logic [3:0] sh_drive, sh_rpga, sh_ipga;
  logic [6:0] sh_rdc, sh_idc;
  logic [7:0] held_red, held_amb, held_ir, held_rc, held_ic;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] stim(input int v, input int j);
    if (j >= 4 && j <= 7) begin
      case (j)
        4: return vecs[v].r0;
        5: return vecs[v].r1;
        6: return vecs[v].r2;
        default: return vecs[v].r3;
      endcase
    end
    if (j >= 11 && j <= 14) return vecs[v].amb;
    if (j >= 18 && j <= 21) return vecs[v].ir;
    return vecs[v].settle;
  endfunction

  // j = edges since the frame start edge; 0..6 RED, 7..13 AMB, 14..20 IR
  task automatic check_phase(input int j);
    int p;
    p = (j <= 6) ? 0 : (j <= 13) ? 1 : 2;
    check("busy", Busy, 1);
    check("led_red", LED_RED, (p == 0));
    check("led_ir", LED_IR, (p == 2));
    check("led_drive", LED_DRIVE, sh_drive);
    check("dc_comp", DC_Comp, (p == 2) ? sh_idc : sh_rdc);
    check("pga_gain", PGA_Gain, (p == 2) ? sh_ipga : sh_rpga);
  endtask

  task automatic check_held();
    check("red_val", RED_ADC_Value, held_red);
    check("amb_val", AMB_ADC_Value, held_amb);
    check("ir_val", IR_ADC_Value, held_ir);
    check("red_corr", RED_Corr, held_rc);
    check("ir_corr", IR_Corr, held_ic);
  endtask

  task automatic check_idle();
    check("idle_busy", Busy, 0);
    check("idle_led_red", LED_RED, 0);
    check("idle_led_ir", LED_IR, 0);
    check("idle_drive", LED_DRIVE, 0);
    check("idle_dc", DC_Comp, 0);
    check("idle_pga", PGA_Gain, 0);
    check("idle_fv", Frame_Valid, 0);
  endtask

  task automatic load_shadow();
    sh_drive = LED_DRIVE_Set;
    sh_rdc   = RED_DC_Comp;
    sh_rpga  = RED_PGA;
    sh_idc   = IR_DC_Comp;
    sh_ipga  = IR_PGA;
  endtask

  task automatic start_frame();
    Enable = 1'b1;
    @(posedge CLK); #1;
    load_shadow();
    check_phase(0);
  endtask

  // Runs edges 1..21 of a frame already started; abort_at drops Enable before that edge,
  // stop_at returns after that edge without finishing.
  task automatic run_frame(input int v, input int abort_at, input int stop_at, input bit change_pga);
    for (int j = 1; j <= 21; j++) begin
      ADC = stim(v, j);
      if (j == abort_at) Enable = 1'b0;
      if (change_pga && j == 15) RED_PGA = 4'd9;
      @(posedge CLK); #1;
      if (j == abort_at) begin
        check_idle();
        check_held();
        return;
      end
      if (j < 21) begin
        check("fv_early", Frame_Valid, 0);
        check_phase(j);
      end else begin
        check("fv_pulse", Frame_Valid, 1);
        held_red = vecs[v].e_red;
        held_amb = vecs[v].e_amb;
        held_ir  = vecs[v].e_ir;
        held_rc  = vecs[v].e_rc;
        held_ic  = vecs[v].e_ic;
        check_held();
        load_shadow();
        check_phase(0);
      end
      if (j == stop_at) return;
    end
  endtask

  initial begin
    vecs[0] = '{8'd0,   8'd200, 8'd200, 8'd200, 8'd200, 8'd40,  8'd150, 8'd200, 8'd40,  8'd150, 8'd160, 8'd110};
    vecs[1] = '{8'd255, 8'd10,  8'd11,  8'd11,  8'd11,  8'd0,   8'd0,   8'd10,  8'd0,   8'd0,   8'd10,  8'd0};
    vecs[2] = '{8'd7,   8'd60,  8'd60,  8'd60,  8'd60,  8'd100, 8'd230, 8'd60,  8'd100, 8'd230, 8'd0,   8'd130};
    vecs[3] = '{8'd0,   8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0,   8'd0};
    vecs[4] = '{8'd99,  8'd7,   8'd6,   8'd5,   8'd4,   8'd5,   8'd6,   8'd5,   8'd5,   8'd6,   8'd0,   8'd1};

    held_red = 0; held_amb = 0; held_ir = 0; held_rc = 0; held_ic = 0;
    rst_n = 1'b0;
    Enable = 1'b0;
    ADC = 8'd0;
    LED_DRIVE_Set = 4'hA;
    RED_DC_Comp = 7'h15;
    RED_PGA = 4'd5;
    IR_DC_Comp = 7'h2A;
    IR_PGA = 4'd3;
    #12;
    check_idle();
    check_held();
    @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK); #1;
    check_idle();

    // Back-to-back frames; RED_PGA changes mid-IR of the first frame
    @(negedge CLK);
    start_frame();
    for (int v = 0; v < 5; v++) run_frame(v, 0, 0, v == 0);

    // Abort on the 2nd IR sample edge, then hold idle
    run_frame(0, 19, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      check_idle();
    end

    // Abort on the final IR sample edge: frame must not publish
    @(negedge CLK);
    start_frame();
    run_frame(2, 21, 0, 1'b0);

    // Async reset mid-AMB, then restart
    @(negedge CLK);
    start_frame();
    run_frame(1, 0, 10, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    held_red = 0; held_amb = 0; held_ir = 0; held_rc = 0; held_ic = 0;
    check_idle();
    check_held();
    @(negedge CLK);
    rst_n = 1'b1;
    start_frame();
    run_frame(0, 0, 0, 1'b0);

    Enable = 1'b0;
    @(posedge CLK); #1;
    check_idle();
    check_held();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
